// File: rtl/decode_pipe.sv
// RV32I decode stage: instruction FIFO, head decode, load-use interlock, registered issue to execute.
// Build option: define DECODE_PIPE_ILLEGAL_EN to flag illegal encodings on illegal_o.
module decode_pipe #(
  parameter int unsigned IBUF_DEPTH = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_inst_i,
  input  logic [XLEN-1:0] if_inst_addr_i,
  input  logic            flush_i,
  output logic [4:0]      reg1_addr_o,
  output logic [4:0]      reg2_addr_o,
  input  logic [XLEN-1:0] reg1_data_i,
  input  logic [XLEN-1:0] reg2_data_i,
  output logic [XLEN-1:0] csr_rd_addr_o,
  input  logic [XLEN-1:0] csr_data_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] op1_jump_o,
  output logic [XLEN-1:0] op2_jump_o,
  output logic [XLEN-1:0] reg1_data_o,
  output logic [XLEN-1:0] reg2_data_o,
  output logic [XLEN-1:0] csr_data_o,
  output logic [XLEN-1:0] csr_wr_addr_o,
  output logic            reg_wr_en_o,
  output logic [4:0]      reg_wr_addr_o,
  output logic            csr_wr_en_o,
  output logic            illegal_o
);

  localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [31:0]     ibuf_inst_q [IBUF_DEPTH];
  logic [XLEN-1:0] ibuf_addr_q [IBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      inst_q, inst_d;
  logic [XLEN-1:0]  inst_addr_q, inst_addr_d, op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0]  op1_jump_q, op1_jump_d, op2_jump_q, op2_jump_d;
  logic [XLEN-1:0]  reg1_data_q, reg1_data_d, reg2_data_q, reg2_data_d;
  logic [XLEN-1:0]  csr_data_q, csr_data_d, csr_wr_addr_q, csr_wr_addr_d;
  logic             reg_wr_en_q, reg_wr_en_d, csr_wr_en_q, csr_wr_en_d;
  logic             illegal_q, illegal_d;
  logic [4:0]       reg_wr_addr_q, reg_wr_addr_d;

  logic            head_valid, push, free, issue, hazard, out_load;
  logic [31:0]     head_inst;
  logic [XLEN-1:0] head_addr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2, dec_legal, dec_load, dec_rwe, dec_cwe, dec_csr, dec_illegal;
  logic [XLEN-1:0] dec_op1, dec_op2, dec_j1, dec_j2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign head_valid = (count_q != '0);
  assign head_inst  = ibuf_inst_q[rd_ptr_q];
  assign head_addr  = ibuf_addr_q[rd_ptr_q];
  assign opcode     = head_inst[6:0];
  assign funct3     = head_inst[14:12];
  assign rd         = head_inst[11:7];
  assign rs1        = head_inst[19:15];
  assign rs2        = head_inst[24:20];

  assign imm_i = {{(XLEN-12){head_inst[31]}}, head_inst[31:20]};
  assign imm_s = {{(XLEN-12){head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
  assign imm_b = {{(XLEN-13){head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                  head_inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                  head_inst[30:21], 1'b0};
  assign imm_u = XLEN'({head_inst[31:12], 12'h000});

  // Head decode; an empty buffer or an illegal encoding decodes to a NOP with no register reads.
  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    dec_legal = 1'b0;
    dec_load  = 1'b0;
    dec_rwe   = 1'b0;
    dec_cwe   = 1'b0;
    dec_csr   = 1'b0;
    dec_op1   = '0;
    dec_op2   = '0;
    dec_j1    = '0;
    dec_j2    = '0;
    case (opcode)
      OPC_LUI:    begin dec_legal = 1'b1; dec_rwe = 1'b1; dec_op1 = imm_u; end
      OPC_AUIPC:  begin dec_legal = 1'b1; dec_rwe = 1'b1; dec_op1 = imm_u; dec_op2 = head_addr; end
      OPC_JAL: begin
        dec_legal = 1'b1; dec_rwe = 1'b1;
        dec_op1 = head_addr; dec_op2 = XLEN'(4); dec_j1 = head_addr; dec_j2 = imm_j;
      end
      OPC_JALR: begin
        dec_legal = (funct3 == 3'b000); dec_rwe = 1'b1; use_rs1 = 1'b1;
        dec_op1 = head_addr; dec_op2 = XLEN'(4); dec_j1 = reg1_data_i; dec_j2 = imm_i;
      end
      OPC_BRANCH: begin
        dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec_j1 = head_addr; dec_j2 = imm_b;
      end
      OPC_LOAD: begin
        dec_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec_load = 1'b1; dec_rwe = 1'b1; use_rs1 = 1'b1; dec_op1 = reg1_data_i; dec_op2 = imm_i;
      end
      OPC_STORE: begin
        dec_legal = (funct3 < 3'b011);
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec_op1 = reg1_data_i; dec_op2 = imm_s;
      end
      OPC_IMM: begin
        dec_legal = 1'b1; dec_rwe = 1'b1; use_rs1 = 1'b1; dec_op1 = reg1_data_i; dec_op2 = imm_i;
      end
      OPC_OP: begin
        dec_legal = (head_inst[31:25] == 7'b0000000) || (head_inst[31:25] == 7'b0100000);
        dec_rwe = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_op1 = reg1_data_i; dec_op2 = reg2_data_i;
      end
      OPC_FENCE: begin
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        dec_j1 = head_addr; dec_j2 = XLEN'(4);
      end
      OPC_SYSTEM: begin
        dec_legal = (funct3 != 3'b100);
        dec_csr   = 1'b1;
        dec_rwe   = (funct3 != 3'b000) && (funct3 != 3'b100);
        dec_cwe   = dec_rwe;
        use_rs1   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      default: dec_legal = 1'b0;
    endcase
`ifdef DECODE_PIPE_ILLEGAL_EN
    dec_illegal = head_valid && !dec_legal;
`else
    dec_illegal = 1'b0;
`endif
    if (!dec_legal || !head_valid) begin
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      dec_load = 1'b0;
      dec_rwe  = 1'b0;
      dec_cwe  = 1'b0;
      dec_csr  = 1'b0;
      dec_op1  = '0;
      dec_op2  = '0;
      dec_j1   = '0;
      dec_j2   = '0;
    end
  end

  assign reg1_addr_o   = use_rs1 ? rs1 : 5'd0;
  assign reg2_addr_o   = use_rs2 ? rs2 : 5'd0;
  assign csr_rd_addr_o = dec_csr ? XLEN'(head_inst[31:20]) : '0;

  // Interlock against a load sitting in the output register or just issued from it.
  assign out_load = ex_valid_q && (inst_q[6:0] == OPC_LOAD);
  assign hazard   = (use_rs1 && (rs1 != 5'd0) &&
                     ((out_load && (rs1 == reg_wr_addr_q)) || (rs1 == ld_rd_q))) ||
                    (use_rs2 && (rs2 != 5'd0) &&
                     ((out_load && (rs2 == reg_wr_addr_q)) || (rs2 == ld_rd_q)));

  assign if_ready_o = (count_q != CNT_W'(IBUF_DEPTH));
  assign push       = if_valid_i && if_ready_o && !flush_i;
  assign free       = !ex_valid_q || ex_ready_i;
  assign issue      = head_valid && free && !hazard && !flush_i;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    ld_rd_d       = 5'd0;
    ex_valid_d    = ex_valid_q;
    inst_d        = inst_q;
    inst_addr_d   = inst_addr_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    op1_jump_d    = op1_jump_q;
    op2_jump_d    = op2_jump_q;
    reg1_data_d   = reg1_data_q;
    reg2_data_d   = reg2_data_q;
    csr_data_d    = csr_data_q;
    csr_wr_addr_d = csr_wr_addr_q;
    reg_wr_en_d   = reg_wr_en_q;
    reg_wr_addr_d = reg_wr_addr_q;
    csr_wr_en_d   = csr_wr_en_q;
    illegal_d     = illegal_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ex_valid_d = 1'b0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(issue);
      if (issue) begin
        ex_valid_d    = 1'b1;
        inst_d        = head_inst;
        inst_addr_d   = head_addr;
        op1_d         = dec_op1;
        op2_d         = dec_op2;
        op1_jump_d    = dec_j1;
        op2_jump_d    = dec_j2;
        reg1_data_d   = reg1_data_i;
        reg2_data_d   = reg2_data_i;
        csr_data_d    = csr_data_i;
        csr_wr_addr_d = csr_rd_addr_o;
        reg_wr_en_d   = dec_rwe;
        reg_wr_addr_d = dec_rwe ? rd : 5'd0;
        csr_wr_en_d   = dec_cwe;
        illegal_d     = dec_illegal;
        ld_rd_d       = dec_load ? rd : 5'd0;
      end else if (free) begin
        ex_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ibuf_inst_q[wr_ptr_q] <= if_inst_i;
      ibuf_addr_q[wr_ptr_q] <= if_inst_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ld_rd_q       <= '0;
      ex_valid_q    <= 1'b0;
      inst_q        <= '0;
      inst_addr_q   <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      op1_jump_q    <= '0;
      op2_jump_q    <= '0;
      reg1_data_q   <= '0;
      reg2_data_q   <= '0;
      csr_data_q    <= '0;
      csr_wr_addr_q <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= '0;
      csr_wr_en_q   <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ld_rd_q       <= ld_rd_d;
      ex_valid_q    <= ex_valid_d;
      inst_q        <= inst_d;
      inst_addr_q   <= inst_addr_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      op1_jump_q    <= op1_jump_d;
      op2_jump_q    <= op2_jump_d;
      reg1_data_q   <= reg1_data_d;
      reg2_data_q   <= reg2_data_d;
      csr_data_q    <= csr_data_d;
      csr_wr_addr_q <= csr_wr_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      csr_wr_en_q   <= csr_wr_en_d;
      illegal_q     <= illegal_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign inst_o        = inst_q;
  assign inst_addr_o   = inst_addr_q;
  assign op1_o         = op1_q;
  assign op2_o         = op2_q;
  assign op1_jump_o    = op1_jump_q;
  assign op2_jump_o    = op2_jump_q;
  assign reg1_data_o   = reg1_data_q;
  assign reg2_data_o   = reg2_data_q;
  assign csr_data_o    = csr_data_q;
  assign csr_wr_addr_o = csr_wr_addr_q;
  assign reg_wr_en_o   = reg_wr_en_q;
  assign reg_wr_addr_o = reg_wr_addr_q;
  assign csr_wr_en_o   = csr_wr_en_q;
  assign illegal_o     = illegal_q;

endmodule
